// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS-style CP0 registers, timer interrupt, exception commit state and TLB op glue.
package cp0_regfile_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int          TLB_IDX_W = 4,
  parameter logic [31:0] RESET_VEC = 32'hBFC00000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wb_we,
  input  logic [7:0]           wb_addr,
  input  logic [31:0]          wb_wdata,
  output logic [31:0]          wb_rdata,
  input  logic                 ex_valid,
  input  logic [4:0]           ex_exccode,
  input  logic                 ex_bd,
  input  logic [31:0]          ex_badvaddr,
  input  logic                 ex_tlb_refill,
  input  logic [31:0]          ex_pc,
  input  logic                 eret,
  input  logic [2:0]           tlb_op,
  input  logic [5:0]           hw_int,
  output logic                 int_req,
  output logic [31:0]          epc,
  output logic [31:0]          ex_target,
  output logic [TLB_IDX_W-1:0] tlbrw_index,
  output logic                 tlbrw_we,
  output tlb_entry_t           tlbrw_wdata,
  input  tlb_entry_t           tlbrw_rdata,
  output logic [31:0]          tlbp_entry_hi,
  input  logic [31:0]          tlbp_index
);
  localparam logic [7:0] A_INDEX = 8'h00, A_LO0 = 8'h10, A_LO1 = 8'h18, A_BADV = 8'h40,
                         A_COUNT = 8'h48, A_EHI = 8'h50, A_CMP = 8'h58, A_STATUS = 8'h60,
                         A_CAUSE = 8'h68, A_EPC = 8'h70;
  logic [7:0]           im, ip;
  logic                 exl, ie, bd, ti, tick, idx_p;
  logic [4:0]           exccode;
  logic [31:0]          count, compare, badvaddr;
  logic [TLB_IDX_W-1:0] idx;
  logic [18:0]          eh_vpn2;
  logic [7:0]           eh_asid;
  logic [25:0]          lo0, lo1;
  logic                 mtc, mt_count, mt_cmp, bad_upd, vpn_upd;
  logic [31:0]          entry_hi;
  logic                 unused_ok;
  assign unused_ok = ^tlbp_index[30:TLB_IDX_W];
  // Lower-priority actions are dropped whenever a higher one commits this cycle.
  assign mtc       = wb_we & ~ex_valid & ~eret & ~|tlb_op;
  assign mt_count  = mtc & (wb_addr == A_COUNT);
  assign mt_cmp    = mtc & (wb_addr == A_CMP);
  assign bad_upd   = ex_exccode >= 5'd1 && ex_exccode <= 5'd5;
  assign vpn_upd   = ex_exccode >= 5'd1 && ex_exccode <= 5'd3;
  assign entry_hi  = {eh_vpn2, 5'b0, eh_asid};
  assign int_req   = ie & ~exl & |(ip & im);
  assign ex_target = (ex_tlb_refill & ~exl) ? RESET_VEC + 32'h200 : RESET_VEC + 32'h380;
  assign tlbrw_index   = idx;
  assign tlbrw_we      = tlb_op[2] & ~ex_valid & ~eret;
  assign tlbrw_wdata   = {eh_vpn2, eh_asid, lo0[0] & lo1[0], lo0[25:1], lo1[25:1]};
  assign tlbp_entry_hi = entry_hi;
  always_comb begin
    wb_rdata = 32'b0;
    case (wb_addr)
      A_INDEX:  wb_rdata = {idx_p, {(31-TLB_IDX_W){1'b0}}, idx};
      A_LO0:    wb_rdata = {6'b0, lo0};
      A_LO1:    wb_rdata = {6'b0, lo1};
      A_BADV:   wb_rdata = badvaddr;
      A_COUNT:  wb_rdata = count;
      A_EHI:    wb_rdata = entry_hi;
      A_CMP:    wb_rdata = compare;
      A_STATUS: wb_rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      A_CAUSE:  wb_rdata = {bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0};
      A_EPC:    wb_rdata = epc;
      default:  wb_rdata = 32'b0;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im <= '0; ip <= '0; exl <= 1'b0; ie <= 1'b0; bd <= 1'b0; ti <= 1'b0; tick <= 1'b0;
      exccode <= '0; count <= '0; compare <= '0; badvaddr <= '0; epc <= '0;
      idx_p <= 1'b0; idx <= '0; eh_vpn2 <= '0; eh_asid <= '0; lo0 <= '0; lo1 <= '0;
    end else begin
      tick    <= mt_count ? 1'b0 : ~tick;
      count   <= mt_count ? wb_wdata : count + 32'(tick);
      ti      <= mt_cmp ? 1'b0 : (ti | (count == compare));
      ip[7:2] <= {hw_int[5] | ti, hw_int[4:0]};
      if (mt_cmp) compare <= wb_wdata;
      if (ex_valid) begin
        if (!exl) begin
          epc <= ex_bd ? ex_pc - 32'd4 : ex_pc;
          bd  <= ex_bd;
        end
        exl     <= 1'b1;
        exccode <= ex_exccode;
        if (bad_upd) badvaddr <= ex_badvaddr;
        if (vpn_upd) eh_vpn2 <= ex_badvaddr[31:13];
      end else if (eret) begin
        exl <= 1'b0;
      end else if (tlb_op[0]) begin
        idx_p <= tlbp_index[31];
        idx   <= tlbp_index[TLB_IDX_W-1:0];
      end else if (tlb_op[1]) begin
        eh_vpn2 <= tlbrw_rdata.vpn2;
        eh_asid <= tlbrw_rdata.asid;
        lo0     <= {tlbrw_rdata.pfn0, tlbrw_rdata.c0, tlbrw_rdata.d0, tlbrw_rdata.v0, tlbrw_rdata.g};
        lo1     <= {tlbrw_rdata.pfn1, tlbrw_rdata.c1, tlbrw_rdata.d1, tlbrw_rdata.v1, tlbrw_rdata.g};
      end else if (mtc) begin
        case (wb_addr)
          A_INDEX:  idx <= wb_wdata[TLB_IDX_W-1:0];
          A_LO0:    lo0 <= wb_wdata[25:0];
          A_LO1:    lo1 <= wb_wdata[25:0];
          A_EHI:    begin eh_vpn2 <= wb_wdata[31:13]; eh_asid <= wb_wdata[7:0]; end
          A_STATUS: begin im <= wb_wdata[15:8]; exl <= wb_wdata[1]; ie <= wb_wdata[0]; end
          A_CAUSE:  ip[1:0] <= wb_wdata[9:8];
          A_EPC:    epc <= wb_wdata;
          default:  ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed table and sequence checks for cp0_regfile.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;
  localparam logic [7:0] A_INDEX = 8'h00, A_LO0 = 8'h10, A_LO1 = 8'h18, A_BADV = 8'h40,
                         A_COUNT = 8'h48, A_EHI = 8'h50, A_CMP = 8'h58, A_STATUS = 8'h60,
                         A_CAUSE = 8'h68, A_EPC = 8'h70;
  logic        clk = 1'b0, resetn = 1'b0, wb_we = 1'b0, ex_valid = 1'b0, ex_bd = 1'b0;
  logic        ex_tlb_refill = 1'b0, eret = 1'b0, int_req, tlbrw_we;
  logic [7:0]  wb_addr = '0;
  logic [31:0] wb_wdata = '0, wb_rdata, ex_badvaddr = '0, ex_pc = '0, epc, ex_target;
  logic [31:0] tlbp_entry_hi, tlbp_index = '0;
  logic [4:0]  ex_exccode = '0;
  logic [2:0]  tlb_op = '0;
  logic [5:0]  hw_int = '0;
  logic [3:0]  tlbrw_index;
  tlb_entry_t  tlbrw_wdata, tlbrw_rdata = '0;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  cp0_regfile dut (
    .clk(clk), .resetn(resetn), .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_rdata(wb_rdata), .ex_valid(ex_valid), .ex_exccode(ex_exccode), .ex_bd(ex_bd),
    .ex_badvaddr(ex_badvaddr), .ex_tlb_refill(ex_tlb_refill), .ex_pc(ex_pc), .eret(eret),
    .tlb_op(tlb_op), .hw_int(hw_int), .int_req(int_req), .epc(epc), .ex_target(ex_target),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
    .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_wdata = d;
    step();
    wb_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    wb_addr = a;
    #1;
    check(name, wb_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{"cmp",        A_CMP,         32'h12345678, 32'h12345678};
    tbl[1]  = '{"status_all", A_STATUS,      32'hFFFFFFFF, 32'h0040FF03};
    tbl[2]  = '{"status_clr", A_STATUS,      32'h00000000, 32'h00400000};
    tbl[3]  = '{"cause_all",  A_CAUSE,       32'hFFFFFFFF, 32'h00000300};
    tbl[4]  = '{"cause_clr",  A_CAUSE,       32'h00000000, 32'h00000000};
    tbl[5]  = '{"epc",        A_EPC,         32'hDEADBEEF, 32'hDEADBEEF};
    tbl[6]  = '{"entryhi",    A_EHI,         32'hFFFFFFFF, 32'hFFFFE0FF};
    tbl[7]  = '{"entrylo0",   A_LO0,         32'hFFFFFFFF, 32'h03FFFFFF};
    tbl[8]  = '{"entrylo1",   A_LO1,         32'h12345678, 32'h02345678};
    tbl[9]  = '{"index",      A_INDEX,       32'hFFFFFFFF, 32'h0000000F};
    tbl[10] = '{"sel1_read",  A_STATUS + 1,  32'hFFFFFFFF, 32'h00000000};
    tbl[11] = '{"sel1_noeff", A_STATUS,      32'h00000000, 32'h00400000};
    // Reset state, sampled before any clock edge.
    #3;
    rd("rst_status", A_STATUS, 32'h00400000);
    rd("rst_cause", A_CAUSE, 32'h0);
    rd("rst_count", A_COUNT, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_int_req", int_req, 1'b0);
    check("rst_tlbrw_we", tlbrw_we, 1'b0);
    #9 resetn = 1'b1;
    wb_addr = A_COUNT;
    repeat (10) @(posedge clk);
    #1;
    check("count_10cyc", wb_rdata, 32'd5);
    for (int i = 0; i < 12; i++) begin
      if (i == 11) mtc0(A_STATUS + 1, 32'hFFFFFFFF);
      else mtc0(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].name, i == 10 ? tbl[i].addr : tbl[i].addr, tbl[i].exp);
    end
    // Hardware interrupt line through IM2.
    mtc0(A_STATUS, 32'h00000401);
    hw_int = 6'b000001;
    step();
    check("hw_int_req", int_req, 1'b1);
    rd("hw_int_ip2", A_CAUSE, 32'h00000400);
    hw_int = '0;
    // Timer interrupt.
    mtc0(A_CMP, 32'd8);
    mtc0(A_STATUS, 32'h00008001);
    mtc0(A_COUNT, 32'd0);
    wb_addr = A_COUNT;
    #1;
    for (int i = 0; i < 40 && wb_rdata != 32'd8; i++) step();
    check("count_reach8", wb_rdata, 32'd8);
    for (int i = 0; i < 4 && !int_req; i++) step();
    check("timer_int_req", int_req, 1'b1);
    wb_addr = A_CAUSE;
    #1;
    check("timer_ti", wb_rdata[30], 1'b1);
    mtc0(A_CMP, 32'd100);
    rd("ti_clear", A_CAUSE, 32'h00008000);
    step();
    check("timer_int_clear", int_req, 1'b0);
    // Exception commit with a concurrent MTC0 EPC that must be dropped.
    ex_valid = 1'b1; ex_exccode = 5'd4; ex_bd = 1'b1; ex_pc = 32'h80001004;
    ex_badvaddr = 32'h3; ex_tlb_refill = 1'b1;
    #1 check("tgt_refill_exl0", ex_target, 32'hBFC00200);
    ex_tlb_refill = 1'b0;
    #1 check("tgt_general", ex_target, 32'hBFC00380);
    mtc0(A_EPC, 32'h11111111);
    ex_valid = 1'b0;
    check("exc_epc", epc, 32'h80001000);
    rd("exc_cause", A_CAUSE, 32'h80000010);
    rd("exc_status", A_STATUS, 32'h00408003);
    rd("exc_badv", A_BADV, 32'h3);
    check("exc_int_masked", int_req, 1'b0);
    // Nested exception while EXL is set.
    ex_valid = 1'b1; ex_exccode = 5'd2; ex_bd = 1'b0; ex_pc = 32'h80002000;
    ex_badvaddr = 32'h12345678; ex_tlb_refill = 1'b1;
    #1 check("tgt_refill_exl1", ex_target, 32'hBFC00380);
    step();
    ex_valid = 1'b0; ex_tlb_refill = 1'b0;
    check("nest_epc", epc, 32'h80001000);
    rd("nest_cause", A_CAUSE, 32'h80000008);
    rd("nest_badv", A_BADV, 32'h12345678);
    rd("nest_entryhi", A_EHI, 32'h123440FF);
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd("eret_status", A_STATUS, 32'h00408001);
    // TLB probe.
    tlbp_index = 32'h80000000; tlb_op = 3'b001;
    step();
    tlb_op = '0;
    rd("tlbp_miss", A_INDEX, 32'h80000000);
    tlbp_index = 32'h00000005; tlb_op = 3'b001;
    step();
    tlb_op = '0;
    rd("tlbp_hit", A_INDEX, 32'h00000005);
    // TLB write-indexed.
    mtc0(A_EHI, 32'hABCDF012);
    mtc0(A_LO0, 32'h00001237);
    mtc0(A_LO1, 32'h00000042);
    check("tlbp_entry_hi", tlbp_entry_hi, 32'hABCDE012);
    check("tlbwi_we_pre", tlbrw_we, 1'b0);
    tlb_op = 3'b100;
    #1;
    check("tlbwi_we", tlbrw_we, 1'b1);
    check("tlbwi_index", tlbrw_index, 4'd5);
    check("tlbwi_wdata", tlbrw_wdata,
          {19'h55E6F, 8'h12, 1'b0, 20'h48, 3'd6, 1'b1, 1'b1, 20'h1, 3'd0, 1'b0, 1'b1});
    step();
    tlb_op = '0;
    #1 check("tlbwi_we_post", tlbrw_we, 1'b0);
    // TLB read.
    tlbrw_rdata = {19'h12345, 8'hA5, 1'b1, 20'hABCDE, 3'd2, 1'b1, 1'b0, 20'h13579, 3'd7, 1'b0, 1'b1};
    tlb_op = 3'b010;
    step();
    tlb_op = '0;
    rd("tlbr_entryhi", A_EHI, 32'h2468A0A5);
    rd("tlbr_lo0", A_LO0, 32'h02AF3795);
    rd("tlbr_lo1", A_LO1, 32'h004D5E7B);
    // Asynchronous reset mid-count.
    repeat (5) step();
    #2 resetn = 1'b0;
    #1;
    rd("areset_count", A_COUNT, 32'h0);
    rd("areset_status", A_STATUS, 32'h00400000);
    rd("areset_ehi", A_EHI, 32'h0);
    check("areset_epc", epc, 32'h0);
    resetn = 1'b1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
